// File: rtl/acc_hash_sequencer.sv
`default_nettype none
// ============================================================================
// acc_hash_sequencer : job sequencer for the SHA-256 accelerator (HCB -> MS/CM -> ACB)
// Rev 1.0
// ============================================================================
module acc_hash_sequencer #(
  parameter int          MEM_LISTEN_ADDR_SIZE    = 16,
  parameter int          MEM_LISTEN_DATA_SIZE    = 32,
  parameter int          MEM_ACC_READ_ADDR_SIZE  = 16,
  parameter int          MEM_ACC_READ_DATA_SIZE  = 512,
  parameter int          MEM_ACC_WRITE_ADDR_SIZE = 16,
  parameter int          MEM_ACC_WRITE_DATA_SIZE = 32,
  parameter int unsigned HCB_MSG_ADDR            = 32'h1008,
  parameter int unsigned BLOCK_ADDR_STRIDE       = 64,
  parameter int unsigned ACB_START_ADDR          = 32'h5000,
  parameter int unsigned ACB_H0_ADDR             = 32'h5008,
  parameter int unsigned WORD_ADDR_STRIDE        = 4,
  parameter int          MAX_BLOCKS              = 4,
  parameter int          HASH_CYCLE_COUNT        = 64,
  parameter int          HASH_RESULT_LENGTH      = 256,
  parameter int          TIMEOUT_CYCLES          = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    mem_listen_en,
  input  logic [MEM_LISTEN_ADDR_SIZE-1:0]         mem_listen_addr,
  input  logic [MEM_LISTEN_DATA_SIZE-1:0]         mem_listen_data,
  input  logic                                    mem_acc_read_data_valid,
  input  logic [MEM_ACC_READ_DATA_SIZE-1:0]       mem_acc_read_data,
  input  logic                                    mem_acc_write_done,
  input  logic [HASH_RESULT_LENGTH-1:0]           cm_out,
  output logic                                    mem_acc_read_en,
  output logic [MEM_ACC_READ_ADDR_SIZE-1:0]       mem_acc_read_addr,
  output logic                                    mem_acc_write_en,
  output logic [MEM_ACC_WRITE_ADDR_SIZE-1:0]      mem_acc_write_addr,
  output logic [MEM_ACC_WRITE_DATA_SIZE-1:0]      mem_acc_write_data,
  output logic                                    ms_init,
  output logic                                    ms_enable,
  output logic                                    cm_is_hashing,
  output logic                                    cm_update_A_H,
  output logic                                    cm_update_H0_7,
  output logic                                    cm_rst_hash_n,
  output logic [$clog2(HASH_CYCLE_COUNT):0]       cm_cycle_count,
  output logic                                    should_save_hash,
  output logic [$clog2(MAX_BLOCKS+1)-1:0]         msg_sel,
  output logic                                    hash_done,
  output logic                                    busy,
  output logic                                    error
);

  localparam int SEL_W  = $clog2(MAX_BLOCKS+1);
  localparam int NWORDS = HASH_RESULT_LENGTH / MEM_ACC_WRITE_DATA_SIZE;
  localparam int W_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = $clog2(HASH_CYCLE_COUNT) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WRITE_BUSY, S_INIT, S_READ_MSG, S_UPD1,
    S_HASH, S_UPD2, S_NEXT, S_WRITE_HASH, S_WRITE_STATUS
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             n_q, n_d;
  logic                   dbl_q, dbl_d;
  logic [SEL_W-1:0]       blk_q, blk_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W_W-1:0]         w_q, w_d;
  logic [TO_W-1:0]        wait_q, wait_d;
  logic                   error_q, error_d;

  logic ctl_wr, start_req, abort_req, timed_out;
  logic digest_pass, more_blocks, need_digest, waiting, handshake;
  logic unused_inputs;

  assign unused_inputs = ^{mem_acc_read_data, mem_listen_data};

  assign ctl_wr      = mem_listen_en && (mem_listen_addr == MEM_LISTEN_ADDR_SIZE'(ACB_START_ADDR));
  assign start_req   = ctl_wr && mem_listen_data[0] && !mem_listen_data[3];
  assign abort_req   = ctl_wr && mem_listen_data[3];
  assign timed_out   = (wait_q == TO_W'(TIMEOUT_CYCLES - 1));
  // blk == MAX_BLOCKS marks the extra pass over the padded first digest
  assign digest_pass = (blk_q == SEL_W'(MAX_BLOCKS));
  assign more_blocks = ({1'b0, n_q} > (9'(blk_q) + 9'd1));
  assign need_digest = dbl_q && !digest_pass;
  assign waiting     = (state_q == S_WRITE_BUSY) || (state_q == S_READ_MSG) ||
                       (state_q == S_WRITE_HASH) || (state_q == S_WRITE_STATUS);
  assign handshake   = (state_q == S_READ_MSG) ? mem_acc_read_data_valid : mem_acc_write_done;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dbl_d   = dbl_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (start_req) begin
        state_d = S_CHECK;
        error_d = 1'b0;
        n_d     = mem_listen_data[15:8];
        dbl_d   = mem_listen_data[4];
        blk_d   = '0;
      end
      S_CHECK: begin
        if (n_q == 8'd0 || n_q > 8'(MAX_BLOCKS)) begin
          error_d = 1'b1;
          state_d = S_WRITE_STATUS;
        end else begin
          state_d = S_WRITE_BUSY;
        end
      end
      S_WRITE_BUSY: begin
        if (mem_acc_write_done)  state_d = S_INIT;
        else if (timed_out)      begin error_d = 1'b1; state_d = S_WRITE_STATUS; end
      end
      S_INIT:     state_d = digest_pass ? S_UPD1 : S_READ_MSG;
      S_READ_MSG: begin
        if (mem_acc_read_data_valid) state_d = S_UPD1;
        else if (timed_out)          begin error_d = 1'b1; state_d = S_WRITE_STATUS; end
      end
      S_UPD1:     state_d = S_HASH;
      S_HASH: begin
        if (cnt_q == CNT_W'(HASH_CYCLE_COUNT)) begin
          cnt_d   = '0;
          state_d = S_UPD2;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_UPD2:     state_d = S_NEXT;
      S_NEXT: begin
        if (more_blocks) begin
          blk_d   = blk_q + 1'b1;
          state_d = S_READ_MSG;
        end else if (need_digest) begin
          blk_d   = SEL_W'(MAX_BLOCKS);
          state_d = S_INIT;
        end else begin
          w_d     = '0;
          state_d = S_WRITE_HASH;
        end
      end
      S_WRITE_HASH: begin
        if (mem_acc_write_done) begin
          if (w_q == W_W'(NWORDS - 1)) begin
            w_d     = '0;
            state_d = S_WRITE_STATUS;
          end else begin
            w_d     = w_q + 1'b1;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = S_WRITE_STATUS;
        end
      end
      S_WRITE_STATUS: if (mem_acc_write_done || timed_out) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Abort outranks any handshake seen in the same cycle
    if (abort_req && state_q != S_IDLE && state_q != S_WRITE_STATUS) begin
      error_d = 1'b1;
      cnt_d   = '0;
      w_d     = '0;
      state_d = S_WRITE_STATUS;
    end

    // Wait counter restarts on every handshake and every state change
    wait_d = (waiting && !handshake && state_d == state_q) ? wait_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      dbl_q   <= 1'b0;
      blk_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      dbl_q   <= dbl_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    mem_acc_read_en    = (state_q == S_READ_MSG);
    mem_acc_read_addr  = '0;
    mem_acc_write_en   = (state_q == S_WRITE_BUSY) || (state_q == S_WRITE_HASH) ||
                         (state_q == S_WRITE_STATUS);
    mem_acc_write_addr = '0;
    mem_acc_write_data = '0;
    if (state_q == S_READ_MSG)
      mem_acc_read_addr = MEM_ACC_READ_ADDR_SIZE'(HCB_MSG_ADDR + 32'(blk_q) * BLOCK_ADDR_STRIDE);
    case (state_q)
      S_WRITE_BUSY: begin
        mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR);
        mem_acc_write_data = MEM_ACC_WRITE_DATA_SIZE'(32'h5);
      end
      S_WRITE_HASH: begin
        mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_H0_ADDR + 32'(w_q) * WORD_ADDR_STRIDE);
        mem_acc_write_data = cm_out[w_q*MEM_ACC_WRITE_DATA_SIZE +: MEM_ACC_WRITE_DATA_SIZE];
      end
      S_WRITE_STATUS: begin
        mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR);
        mem_acc_write_data = error_q ? MEM_ACC_WRITE_DATA_SIZE'(32'hA) : MEM_ACC_WRITE_DATA_SIZE'(32'h2);
      end
      default: ;
    endcase
  end

  assign ms_init          = (state_q == S_UPD1);
  assign cm_update_A_H    = (state_q == S_UPD1);
  assign ms_enable        = (state_q == S_HASH) && (cnt_q < CNT_W'(HASH_CYCLE_COUNT));
  assign cm_is_hashing    = ms_enable;
  assign cm_update_H0_7   = (state_q == S_UPD2);
  assign cm_rst_hash_n    = (state_q != S_INIT);
  assign cm_cycle_count   = cnt_q;
  assign should_save_hash = (state_q == S_NEXT);
  assign hash_done        = (state_q == S_NEXT) && !more_blocks && !need_digest;
  assign msg_sel          = blk_q;
  assign busy             = (state_q != S_IDLE);
  assign error            = error_q;

endmodule
`default_nettype wire

// File: doc/acc_hash_sequencer.md
# acc_hash_sequencer

Parametrised successor control FSM for the SHA-256 accelerator, sitting between the CPU data-memory listen port, the memory arbiter, the Message Scheduler (MS) and the Compressor (CM). It hashes a job of 1..MAX_BLOCKS 512-bit message blocks read from the HCB. In double-hash mode it runs one extra pass over the padded first digest. It writes the 256-bit digest and status words to the ACB through a word loop. It adds arbiter watchdog timeouts, CPU abort and job-descriptor validation.

## Interface
- MEM_LISTEN_ADDR_SIZE, 16, listen address width
- MEM_LISTEN_DATA_SIZE, 32, listen data width
- MEM_ACC_READ_ADDR_SIZE, 16, read address width
- MEM_ACC_READ_DATA_SIZE, 512, read data width (one block)
- MEM_ACC_WRITE_ADDR_SIZE, 16, write address width
- MEM_ACC_WRITE_DATA_SIZE, 32, write data width; must divide HASH_RESULT_LENGTH
- HCB_MSG_ADDR, 16'h1008, address of block 0
- BLOCK_ADDR_STRIDE, 64, address step between blocks
- ACB_START_ADDR, 16'h5000, control/status word address
- ACB_H0_ADDR, 16'h5008, digest word 0 address
- WORD_ADDR_STRIDE, 4, address step between digest words
- MAX_BLOCKS, 4, maximum blocks per job
- HASH_CYCLE_COUNT, 64, compression rounds
- HASH_RESULT_LENGTH, 256, digest width
- TIMEOUT_CYCLES, 1024, arbiter wait limit
- Derived: SEL_W = $clog2(MAX_BLOCKS+1); NWORDS = HASH_RESULT_LENGTH/MEM_ACC_WRITE_DATA_SIZE
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_listen_en / mem_listen_addr / mem_listen_data  in  1 / LISTEN_ADDR / LISTEN_DATA  CPU write snoop
- mem_acc_read_data_valid  in  1  arbiter read grant + data valid
- mem_acc_read_data  in  READ_DATA  block data (pass-through to datapath, not latched here)
- mem_acc_write_done  in  1  arbiter write complete
- cm_out  in  HASH_RESULT_LENGTH  CM digest
- mem_acc_read_en / mem_acc_read_addr  out  1 / READ_ADDR  read request
- mem_acc_write_en / mem_acc_write_addr / mem_acc_write_data  out  1 / WRITE_ADDR / WRITE_DATA  write request
- ms_init, ms_enable  out  1 each  MS control
- cm_is_hashing, cm_update_A_H, cm_update_H0_7, cm_rst_hash_n  out  1 each  CM control
- cm_cycle_count  out  $clog2(HASH_CYCLE_COUNT)+1  round counter
- should_save_hash  out  1  latch intermediate digest
- msg_sel  out  SEL_W  block index; value MAX_BLOCKS selects the padded-digest pass
- hash_done  out  1  one-cycle digest-ready pulse
- busy  out  1  job in progress
- error  out  1  sticky error of last job

## Operation
- Control word (CPU write to ACB_START_ADDR): bit0 start, bit3 abort, bit4 double mode, bits[15:8] block count N.
- Status words: busy 32'h5, done 32'h2, error 32'hA.
- IDLE: start -> CHECK. Start clears error, latches N and double mode, and zeroes blk.
- CHECK: if N==0 or N>MAX_BLOCKS -> WRITE_STATUS(error); otherwise -> WRITE_BUSY.
- WRITE_BUSY: write 32'h5 to ACB_START_ADDR; on write_done -> INIT.
- INIT: cm_rst_hash_n=0, one cycle -> READ_MSG on the first pass, or UPD1 on the digest pass.
- READ_MSG: read_en=1, addr = HCB_MSG_ADDR + blk*BLOCK_ADDR_STRIDE, msg_sel=blk; on valid -> UPD1.
- UPD1: cm_update_A_H=1, ms_init=1 -> HASH.
- HASH: while counter<HASH_CYCLE_COUNT, assert cm_is_hashing, ms_enable and increment the counter. At counter==HASH_CYCLE_COUNT, clear the counter -> UPD2.
- UPD2: cm_update_H0_7=1 -> NEXT.
- NEXT: should_save_hash=1.
  - blk+1<N: blk++ -> READ_MSG.
  - Otherwise, double mode and first pass: blk=MAX_BLOCKS -> INIT.
  - Otherwise: hash_done=1 -> WRITE_HASH with w=0.
- WRITE_HASH: addr = ACB_H0_ADDR + w*WORD_ADDR_STRIDE, data = cm_out[32w+31:32w]. On write_done: w==NWORDS-1 -> WRITE_STATUS(done), else w++.
- WRITE_STATUS: write the done or error word; on write_done -> IDLE.
- Timeout: a wait counter runs in READ_MSG, WRITE_BUSY and WRITE_HASH.
  - Reaching TIMEOUT_CYCLES-1 without valid/done sets error and jumps to WRITE_STATUS(error).
  - A timeout in WRITE_STATUS -> IDLE, error kept.
- Abort: a listen write to ACB_START_ADDR with bit3 set, in any state except IDLE or WRITE_STATUS, sets error and jumps to WRITE_STATUS(error).
- Priority:
  - abort beats valid/done in the same cycle, and valid/done beat timeout.
  - A start in IDLE with bit3 set is ignored.
  - Listen writes other than abort are ignored while busy.
- busy = (state != IDLE). msg_sel = blk.

## Timing
- Request/control outputs are combinational from state; state and counters are registered.
- Reset (async, immediate): state IDLE, all counters and error 0. All outputs 0 except cm_rst_hash_n=1.
- Reset asserted mid-job aborts silently with no status write.
- Start seen in cycle t -> CHECK at t+1, write_en at t+2.
- Requests are held until valid/done; the state advances the cycle after it.
- Per block: read wait + 1 (UPD1) + 65 (HASH) + 1 (UPD2) + 1 (NEXT).
- Arbiter latency 0 means valid is already high in the first request cycle.
- hash_done is high for exactly one cycle per successful job.

## Test plan
- N=1, single mode, zero-latency arbiter -> busy write 0x5, one read at 0x1008, 65-cycle HASH, 8 writes to 0x5008..0x5024 (word 0 = cm_out[31:0]), then 0x2 at 0x5000, hash_done pulsed once.
- N=2, double mode -> reads at 0x1008 and 0x1048, third pass with msg_sel=4 and no read, should_save_hash pulsed 3 times, INIT twice.
- N=0 and N=5 -> no busy write, single write of 0xA, error=1; the next valid start clears error.
- Arbiter never grants read -> after 1024 wait cycles, 0xA is written and error=1; a grant arriving on the same cycle as the timeout is accepted instead.
- Abort at HASH round 30 -> next state WRITE_STATUS, 0xA written, no digest words written.
- rst pulsed during WRITE_HASH word 3 -> outputs immediately at reset values; a fresh start completes normally.
